// File: rtl/nco_phase_acc.sv
// NCO stage: phase accumulator followed by a quarter-wave sine LUT pipeline.
// Produces an offset-binary DAC sample, a square wave and a wrap strobe.
module nco_phase_acc #(
  parameter int PHINC_W    = 8,
  parameter int ACC_W      = 16,
  parameter int LUT_ADDR_W = 6,
  parameter int DAC_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               phase_clr,
  input  logic [PHINC_W-1:0] phinc,
  output logic [DAC_W-1:0]   dac_out,
  output logic               sq_out,
  output logic               wrap,
  output logic               out_valid
);

  localparam int MAG_W = DAC_W - 1;
  localparam logic [DAC_W-1:0] MID = {1'b1, {(DAC_W-1){1'b0}}};

  // First quadrant of round(127 * sin(pi/2 * (k + 0.5) / 64)), k = 0..63.
  localparam logic [MAG_W-1:0] SINE_ROM [64] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  logic [PHINC_W-1:0]    phinc_q;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W:0]        acc_sum;
  logic [1:0]            quad;
  logic [LUT_ADDR_W-1:0] idx_raw;
  logic [LUT_ADDR_W-1:0] idx_b;
  logic                  sign_b;
  logic                  sign_c;
  logic [MAG_W-1:0]      mag_c;
  logic                  v_a;
  logic                  v_b;
  logic                  v_c;

  assign acc_sum = {1'b0, acc} + (ACC_W+1)'(phinc_q);
  assign quad    = acc[ACC_W-1 -: 2];
  assign idx_raw = acc[ACC_W-3 -: LUT_ADDR_W];

  // out_valid is a plain qualifier with no ready: it is en as sampled by the
  // accumulator stage, carried alongside the sample through the three
  // downstream stages. phase_clr does not affect it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phinc_q   <= '0;
      acc       <= '0;
      wrap      <= 1'b0;
      v_a       <= 1'b0;
      sq_out    <= 1'b0;
      idx_b     <= '0;
      sign_b    <= 1'b0;
      v_b       <= 1'b0;
      mag_c     <= '0;
      sign_c    <= 1'b0;
      v_c       <= 1'b0;
      dac_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      phinc_q <= phinc;
      v_a     <= en;
      if (phase_clr) begin
        acc  <= '0;
        wrap <= 1'b0;
      end else if (en) begin
        acc  <= acc_sum[ACC_W-1:0];
        wrap <= acc_sum[ACC_W];
      end else begin
        wrap <= 1'b0;
      end

      // Odd quadrants walk the quarter-wave table backwards.
      sq_out <= acc[ACC_W-1];
      idx_b  <= quad[0] ? ~idx_raw : idx_raw;
      sign_b <= quad[1];
      v_b    <= v_a;

      mag_c  <= SINE_ROM[idx_b];
      sign_c <= sign_b;
      v_c    <= v_b;

      dac_out   <= sign_c ? (MID - DAC_W'(mag_c)) : (MID + DAC_W'(mag_c));
      out_valid <= v_c;
    end
  end

endmodule

// File: tb/tb_nco_phase_acc.sv
// Bench for nco_phase_acc: random-free scenario tasks plus random phinc runs,
// checked against an arithmetic phase/sine model with an expected-sample queue.
module tb_nco_phase_acc;

  localparam int PHINC_W    = 8;
  localparam int ACC_W      = 16;
  localparam int LUT_ADDR_W = 6;
  localparam int DAC_W      = 8;
  localparam real PI        = 3.14159265358979;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               en = 1'b0;
  logic               phase_clr = 1'b0;
  logic [PHINC_W-1:0] phinc = '0;
  logic [DAC_W-1:0]   dac_out;
  logic               sq_out;
  logic               wrap;
  logic               out_valid;

  int errors = 0;
  int checks = 0;

  // clock / reset block
  always #5 clk = ~clk;

  nco_phase_acc #(
    .PHINC_W(PHINC_W), .ACC_W(ACC_W), .LUT_ADDR_W(LUT_ADDR_W), .DAC_W(DAC_W)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .phase_clr(phase_clr), .phinc(phinc),
    .dac_out(dac_out), .sq_out(sq_out), .wrap(wrap), .out_valid(out_valid)
  );

  // reference model state
  int unsigned      m_acc;
  int unsigned      m_phq;
  int unsigned      m_n;
  logic             m_wrap;
  logic             m_sq;
  logic [DAC_W-1:0] exp_q[$];
  logic             v_q[$];
  logic [DAC_W-1:0] e_dac;
  logic             e_valid;

  // Sample value for a phase, straight from the sine definition.
  function automatic logic [DAC_W-1:0] dac_of(input int unsigned a);
    int unsigned q, quadr, r, k;
    int mag, half;
    half  = 1 << (DAC_W - 1);
    q     = a >> (ACC_W - 2 - LUT_ADDR_W);
    quadr = q >> LUT_ADDR_W;
    r     = q % (1 << LUT_ADDR_W);
    k     = (quadr % 2 == 1) ? ((1 << LUT_ADDR_W) - 1 - r) : r;
    mag   = $rtoi(real'(half - 1) * $sin(PI / 2.0 * (real'(k) + 0.5) / real'(1 << LUT_ADDR_W)) + 0.5);
    return DAC_W'((quadr >= 2) ? (half - mag) : (half + mag));
  endfunction

  task automatic model_reset();
    m_acc  = 0;
    m_phq  = 0;
    m_n    = 0;
    m_wrap = 1'b0;
    m_sq   = 1'b0;
    exp_q  = {};
    v_q    = {};
    repeat (3) begin
      exp_q.push_back(dac_of(0));
      v_q.push_back(1'b0);
    end
  endtask

  // Advance one clock and update the model with the inputs seen at that edge.
  task automatic tick();
    int unsigned s;
    @(posedge clk);
    #1;
    m_sq = ((m_acc >> (ACC_W - 1)) & 1) != 0;
    if (phase_clr) begin
      m_acc  = 0;
      m_wrap = 1'b0;
    end else if (en) begin
      s      = m_acc + m_phq;
      m_wrap = (s >= (1 << ACC_W));
      m_acc  = s % (1 << ACC_W);
    end else begin
      m_wrap = 1'b0;
    end
    m_phq = phinc;
    exp_q.push_back(dac_of(m_acc));
    v_q.push_back(en);
    e_dac   = exp_q.pop_front();
    e_valid = v_q.pop_front();
    m_n++;
  endtask

  // driver: clear phase and load an increment; acc is 0 with phinc_q loaded
  task automatic start(input logic [PHINC_W-1:0] inc);
    phinc     = inc;
    en        = 1'b1;
    phase_clr = 1'b1;
    tick();
    tick();
    phase_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en    = 1'b1;
    phinc = '0;
    model_reset();
    #22;
    checks++; if (dac_out !== '0) begin errors++; $display("FAIL reset_dac got=%0d exp=0", dac_out); end
    checks++; if (sq_out !== 1'b0) begin errors++; $display("FAIL reset_sq got=%b exp=0", sq_out); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    reset = 1'b1;
  endtask

  task automatic test_zero_inc(input string tag);
    for (int t = 1; t <= 12; t++) begin
      tick();
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL %s_wrap edge=%0d got=%b exp=0", tag, t, wrap); end
      checks++; if (sq_out !== 1'b0) begin errors++; $display("FAIL %s_sq edge=%0d got=%b exp=0", tag, t, sq_out); end
      checks++; if (out_valid !== (t >= 4)) begin errors++; $display("FAIL %s_valid edge=%0d got=%b exp=%b", tag, t, out_valid, (t >= 4)); end
      if (t >= 4) begin
        checks++; if (dac_out !== 8'd130) begin errors++; $display("FAIL %s_dac edge=%0d got=%0d exp=130", tag, t, dac_out); end
      end
    end
  endtask

  task automatic test_phinc64();
    int wraps, run, runs_seen, dmax, dmin;
    logic prev_wrap;
    wraps = 0; run = 0; runs_seen = 0; dmax = 0; dmin = 255; prev_wrap = 1'b0;
    start(8'd64);
    for (int t = 1; t <= 2048; t++) begin
      tick();
      checks++; if (dac_out !== e_dac) begin errors++; $display("FAIL p64_dac edge=%0d got=%0d exp=%0d", t, dac_out, e_dac); end
      checks++; if (wrap !== m_wrap) begin errors++; $display("FAIL p64_wrap edge=%0d got=%b exp=%b", t, wrap, m_wrap); end
      checks++; if (sq_out !== m_sq) begin errors++; $display("FAIL p64_sq edge=%0d got=%b exp=%b", t, sq_out, m_sq); end
      checks++; if (out_valid !== e_valid) begin errors++; $display("FAIL p64_valid edge=%0d got=%b exp=%b", t, out_valid, e_valid); end
      if (wrap === 1'b1) wraps++;
      if (wrap === 1'b1 && prev_wrap === 1'b1) begin
        checks++; errors++; $display("FAIL p64_wrap_width edge=%0d got=2 exp=1", t);
      end
      prev_wrap = wrap;
      if (sq_out === 1'b1) run++;
      else if (run != 0) begin
        runs_seen++;
        checks++; if (run != 512) begin errors++; $display("FAIL p64_sq_run got=%0d exp=512", run); end
        run = 0;
      end
      if (int'(dac_out) > dmax) dmax = int'(dac_out);
      if (int'(dac_out) < dmin) dmin = int'(dac_out);
    end
    checks++; if (wraps != 2) begin errors++; $display("FAIL p64_wrap_count got=%0d exp=2", wraps); end
    checks++; if (runs_seen < 1) begin errors++; $display("FAIL p64_sq_runs got=%0d exp>=1", runs_seen); end
    checks++; if (dmax != 255) begin errors++; $display("FAIL p64_peak got=%0d exp=255", dmax); end
    checks++; if (dmin != 1) begin errors++; $display("FAIL p64_trough got=%0d exp=1", dmin); end
  endtask

  task automatic test_phinc255();
    int wraps, last;
    logic prev_wrap;
    wraps = 0; last = 0; prev_wrap = 1'b0;
    start(8'd255);
    for (int t = 1; t <= 65280; t++) begin
      tick();
      checks++; if (dac_out !== e_dac) begin errors++; $display("FAIL p255_dac edge=%0d got=%0d exp=%0d", t, dac_out, e_dac); end
      checks++; if (wrap !== m_wrap) begin errors++; $display("FAIL p255_wrap edge=%0d got=%b exp=%b", t, wrap, m_wrap); end
      if (wrap === 1'b1) begin
        wraps++;
        checks++;
        if ((t - last) != 257 && (t - last) != 258) begin
          errors++; $display("FAIL p255_interval edge=%0d got=%0d exp=257or258", t, t - last);
        end
        if (prev_wrap === 1'b1) begin
          errors++; $display("FAIL p255_back_to_back edge=%0d got=1 exp=0", t);
        end
        last = t;
      end
      prev_wrap = wrap;
    end
    checks++; if (wraps != 254) begin errors++; $display("FAIL p255_wrap_count got=%0d exp=254", wraps); end
  endtask

  task automatic test_hold();
    start(8'd64);
    repeat (192) tick();
    en = 1'b0;
    for (int t = 1; t <= 100; t++) begin
      tick();
      checks++; if (dac_out !== e_dac) begin errors++; $display("FAIL hold_dac_model edge=%0d got=%0d exp=%0d", t, dac_out, e_dac); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL hold_wrap edge=%0d got=%b exp=0", t, wrap); end
      checks++; if (out_valid !== (t <= 3)) begin errors++; $display("FAIL hold_valid edge=%0d got=%b exp=%b", t, out_valid, (t <= 3)); end
      if (t >= 3) begin
        checks++; if (dac_out !== 8'd246) begin errors++; $display("FAIL hold_dac edge=%0d got=%0d exp=246", t, dac_out); end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_clr_en();
    start(8'd64);
    repeat (1023) tick();
    phase_clr = 1'b1;
    tick();
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL clr_at_ffc0_wrap got=%b exp=0", wrap); end
    phase_clr = 1'b0;
    repeat (513) tick();
    phinc     = '0;
    phase_clr = 1'b1;
    tick();
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL clr_wrap got=%b exp=0", wrap); end
    checks++; if (sq_out !== 1'b1) begin errors++; $display("FAIL clr_sq_before got=%b exp=1", sq_out); end
    phase_clr = 1'b0;
    tick();
    checks++; if (sq_out !== 1'b0) begin errors++; $display("FAIL clr_sq_after got=%b exp=0", sq_out); end
    tick();
    checks++; if (dac_out !== 8'd126) begin errors++; $display("FAIL clr_dac_old got=%0d exp=126", dac_out); end
    tick();
    checks++; if (dac_out !== 8'd130) begin errors++; $display("FAIL clr_dac_new got=%0d exp=130", dac_out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_valid got=%b exp=1", out_valid); end
  endtask

  task automatic test_random_inc();
    logic [PHINC_W-1:0] inc;
    for (int seg = 0; seg < 8; seg++) begin
      inc       = PHINC_W'($urandom_range(0, (1 << PHINC_W) - 1));
      phinc     = inc;
      en        = ($urandom_range(0, 3) != 0);
      phase_clr = ($urandom_range(0, 7) == 0);
      for (int t = 1; t <= 300; t++) begin
        tick();
        checks++; if (dac_out !== e_dac) begin errors++; $display("FAIL rnd_dac inc=%0d edge=%0d got=%0d exp=%0d", inc, t, dac_out, e_dac); end
        checks++; if (wrap !== m_wrap) begin errors++; $display("FAIL rnd_wrap inc=%0d edge=%0d got=%b exp=%b", inc, t, wrap, m_wrap); end
        checks++; if (sq_out !== m_sq) begin errors++; $display("FAIL rnd_sq inc=%0d edge=%0d got=%b exp=%b", inc, t, sq_out, m_sq); end
        checks++; if (out_valid !== e_valid) begin errors++; $display("FAIL rnd_valid inc=%0d edge=%0d got=%b exp=%b", inc, t, out_valid, e_valid); end
        phase_clr = 1'b0;
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    start(8'd64);
    repeat (300) tick();
    #2;
    reset = 1'b0;
    phinc = '0;
    #1;
    checks++; if (dac_out !== '0) begin errors++; $display("FAIL mid_reset_dac got=%0d exp=0", dac_out); end
    checks++; if (sq_out !== 1'b0) begin errors++; $display("FAIL mid_reset_sq got=%b exp=0", sq_out); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL mid_reset_wrap got=%b exp=0", wrap); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got=%b exp=0", out_valid); end
    #2;
    reset = 1'b1;
    model_reset();
    test_zero_inc("after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_zero_inc("zero_inc");
    test_phinc64();
    test_phinc255();
    test_hold();
    test_clr_en();
    test_random_inc();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
